// File: rtl/gan_fx_pkg.sv
// Shared fixed-point definitions for the GAN datapath layers.
// Holds the default data format, activation encodings, the layer FSM state
// type, the accumulator sizing rule and a saturate-to-width helper.
// No ports (package).
package gan_fx_pkg;

  // Default Q8.8 data format
  localparam int unsigned GAN_DW   = 16;
  localparam int unsigned GAN_FRAC = 8;
  localparam int unsigned FX_ONE   = 1 << GAN_FRAC;

  // Activation selectors
  localparam int unsigned ACT_NONE  = 0;
  localparam int unsigned ACT_HTANH = 1;
  localparam int unsigned ACT_RELU  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Accumulator wide enough for n_in full products plus a scaled bias
  function automatic int unsigned acc_width(input int unsigned dw,
                                            input int unsigned n_in);
    return 2 * dw + $clog2(n_in + 1);
  endfunction

  // Clamp a signed value to the range of a dw-bit two's-complement number
  function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] v,
                                                   input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fx_mac.sv
// Registered signed multiply-accumulate.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   clr       - zero the accumulator (wins over en)
//   en        - add the full-width product a*b into acc
//   a, b      - signed DW-bit operands
//   acc       - signed AW-bit accumulator (registered)
module fx_mac #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 34
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  localparam int unsigned PW = 2 * DW;

  logic signed [PW-1:0] prod_c;

  // Full-precision product, operands sign-extended first
  assign prod_c = PW'(a) * PW'(b);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + AW'(prod_c);
    end
  end

endmodule

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: N_OUT neurons of
// y = act(sum(x_i * w_i) + b) computed one product per cycle on one MAC.
// Optional build macro: DENSE_SAT_EN (saturate instead of wrap before the
// activation).
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   in_valid      - input vector valid
//   in_ready      - layer idle and able to accept a vector
//   in_vec        - N_IN signed DW-bit inputs, element i at [DW*i +: DW]
//   flat_weights  - per neuron N_IN weights then bias, slot s at [DW*s +: DW];
//                   must stay stable from accept until out_valid
//   out_valid     - result vector valid (held until out_ready)
//   out_ready     - downstream accepts the result
//   out_vec       - N_OUT signed DW-bit results, neuron n at [DW*n +: DW]
//   busy          - computing (MAC or ACT phase)
module dense_layer_seq
  import gan_fx_pkg::*;
#(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned DW    = GAN_DW,
  parameter int unsigned FRAC  = GAN_FRAC,
  parameter int unsigned ACT   = ACT_HTANH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_IN*DW-1:0]              in_vec,
  input  logic [N_OUT*(N_IN+1)*DW-1:0]    flat_weights,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_OUT*DW-1:0]             out_vec,
  output logic                            busy
);

  localparam int unsigned AW = acc_width(DW, N_IN);
  localparam int unsigned SW = AW + 1;
  localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [IW-1:0]        I_LAST = IW'(N_IN - 1);
  localparam logic [NW-1:0]        N_LAST = NW'(N_OUT - 1);
  localparam logic signed [DW-1:0] ONE_FX = DW'(1 << FRAC);

  state_e               state_q;
  state_e               state_d;
  logic [IW-1:0]        i_q;
  logic [IW-1:0]        i_d;
  logic [NW-1:0]        n_q;
  logic [NW-1:0]        n_d;

  logic signed [DW-1:0] x_q   [N_IN];
  logic signed [DW-1:0] out_q [N_OUT];
  logic signed [DW-1:0] w_c   [N_OUT][N_IN];
  logic signed [DW-1:0] b_c   [N_OUT];

  logic                 accept_c;
  logic                 mac_clr_c;
  logic                 mac_en_c;
  logic                 act_wr_c;

  logic signed [DW-1:0] x_sel_c;
  logic signed [DW-1:0] w_sel_c;
  logic signed [DW-1:0] b_sel_c;
  logic signed [AW-1:0] acc;
  logic signed [SW-1:0] biased_c;
  logic signed [SW-1:0] shifted_c;
  logic signed [DW-1:0] red_c;
  logic signed [DW-1:0] act_c;

  // Unpack the flat weight bus and drive the packed result bus
  for (genvar n = 0; n < N_OUT; n++) begin : g_neuron
    for (genvar k = 0; k < N_IN; k++) begin : g_in
      assign w_c[n][k] = flat_weights[DW*(n*(N_IN+1)+k) +: DW];
    end
    assign b_c[n] = flat_weights[DW*(n*(N_IN+1)+N_IN) +: DW];
    assign out_vec[DW*n +: DW] = out_q[n];
  end

  assign accept_c = in_valid & in_ready;
  assign x_sel_c  = x_q[i_q];
  assign w_sel_c  = w_c[n_q][i_q];
  assign b_sel_c  = b_c[n_q];

  fx_mac #(
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr_c),
    .en  (mac_en_c),
    .a   (x_sel_c),
    .b   (w_sel_c),
    .acc (acc)
  );

  // Bias aligned to the product scale, then floor-shift back to FRAC bits
  assign biased_c  = SW'(acc) + (SW'(b_sel_c) <<< FRAC);
  assign shifted_c = biased_c >>> FRAC;

  // Reduce to DW bits: clamp or two's-complement wrap
  always_comb begin
`ifdef DENSE_SAT_EN
    red_c = DW'(sat_to_dw(64'(shifted_c), DW));
`else
    red_c = DW'(shifted_c);
`endif
  end

  // Activation
  always_comb begin
    act_c = red_c;
    if (ACT == ACT_HTANH) begin
      if (red_c > ONE_FX) begin
        act_c = ONE_FX;
      end else if (red_c < -ONE_FX) begin
        act_c = -ONE_FX;
      end
    end else if (ACT == ACT_RELU) begin
      if (red_c < 0) begin
        act_c = '0;
      end
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    i_d       = i_q;
    mac_clr_c = 1'b0;
    mac_en_c  = 1'b0;
    act_wr_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d   = ST_MAC;
          n_d       = '0;
          i_d       = '0;
          mac_clr_c = 1'b1;
        end
      end
      ST_MAC: begin
        mac_en_c = 1'b1;
        if (i_q == I_LAST) begin
          state_d = ST_ACT;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      ST_ACT: begin
        act_wr_c = 1'b1;
        if (n_q == N_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_MAC;
          n_d       = n_q + NW'(1);
          i_d       = '0;
          mac_clr_c = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, latched inputs, results and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      i_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int k = 0; k < int'(N_IN); k++) begin
        x_q[k] <= '0;
      end
      for (int n = 0; n < int'(N_OUT); n++) begin
        out_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      i_q       <= i_d;
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
      busy      <= (state_d == ST_MAC) || (state_d == ST_ACT);
      if (accept_c) begin
        for (int k = 0; k < int'(N_IN); k++) begin
          x_q[k] <= in_vec[DW*k +: DW];
        end
      end
      if (act_wr_c) begin
        out_q[n_q] <= act_c;
      end
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Self-checking bench for dense_layer_seq: three instances (identity, hard
// tanh, ReLU) share stimulus; results are compared against an arithmetic
// reference of the neuron equation. Honours DENSE_SAT_EN like the design.
module tb_dense_layer_seq;

  localparam int N_IN  = 2;
  localparam int N_OUT = 3;
  localparam int DW    = 16;
  localparam int IN_W  = N_IN * DW;
  localparam int W_W   = N_OUT * (N_IN + 1) * DW;
  localparam int OUT_W = N_OUT * DW;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [IN_W-1:0]  in_vec;
  logic [W_W-1:0]   flat_weights;
  logic             out_ready;

  logic             rdy_id, rdy_ht, rdy_re;
  logic             ov_id, ov_ht, ov_re;
  logic             busy_id, busy_ht, busy_re;
  logic [OUT_W-1:0] ovec_id, ovec_ht, ovec_re;

  int n_checks;
  int n_pass;

  dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(8), .ACT(0)) u_id (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_id), .in_vec(in_vec),
    .flat_weights(flat_weights), .out_valid(ov_id), .out_ready(out_ready),
    .out_vec(ovec_id), .busy(busy_id));

  dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(8), .ACT(1)) u_ht (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_ht), .in_vec(in_vec),
    .flat_weights(flat_weights), .out_valid(ov_ht), .out_ready(out_ready),
    .out_vec(ovec_ht), .busy(busy_ht));

  dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(8), .ACT(2)) u_re (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_re), .in_vec(in_vec),
    .flat_weights(flat_weights), .out_valid(ov_re), .out_ready(out_ready),
    .out_vec(ovec_re), .busy(busy_re));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference neuron: exact integer sum, floor divide by 2^8, reduce, activate
  function automatic logic [15:0] ref_neuron(input logic [IN_W-1:0] x,
                                             input logic [W_W-1:0] w,
                                             input int n, input int act);
    longint     sum;
    longint     s;
    logic [15:0] xe;
    logic [15:0] we;
    sum = 0;
    for (int k = 0; k < N_IN; k++) begin
      xe = x[16*k +: 16];
      we = w[16*(n*(N_IN+1)+k) +: 16];
      sum += longint'($signed(xe)) * longint'($signed(we));
    end
    we = w[16*(n*(N_IN+1)+N_IN) +: 16];
    sum += longint'($signed(we)) * 256;
    s = sum / 256;
    if (sum < 0 && (sum % 256) != 0) s = s - 1;
`ifdef DENSE_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`else
    s = s & 64'hFFFF;
    if (s > 32767) s = s - 65536;
`endif
    if (act == 1) begin
      if (s > 256) s = 256;
      else if (s < -256) s = -256;
    end else if (act == 2) begin
      if (s < 0) s = 0;
    end
    return s[15:0];
  endfunction

  function automatic logic [OUT_W-1:0] ref_vec(input logic [IN_W-1:0] x,
                                               input logic [W_W-1:0] w, input int act);
    logic [OUT_W-1:0] v;
    for (int n = 0; n < N_OUT; n++) begin
      v[16*n +: 16] = ref_neuron(x, w, n, act);
    end
    return v;
  endfunction

  // One vector through all three layers, with hold cycles of backpressure
  task automatic do_txn(input logic [IN_W-1:0] x, input logic [W_W-1:0] w, input int hold,
                        output logic [OUT_W-1:0] got_id, output logic [OUT_W-1:0] got_ht,
                        output logic [OUT_W-1:0] got_re);
    logic [OUT_W-1:0] e_id, e_ht, e_re;
    int lat;
    e_id = ref_vec(x, w, 0);
    e_ht = ref_vec(x, w, 1);
    e_re = ref_vec(x, w, 2);
    in_vec       = x;
    flat_weights = w;
    in_valid     = 1'b1;
    out_ready    = 1'b0;
    lat = 0;
    while (!rdy_id && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("in_ready_idle", 64'(rdy_id), 64'd1);
    @(posedge clk); #1;
    // Garbage on the input bus while busy must neither be accepted nor used
    in_vec = ~x;
    check("busy_after_accept", 64'(busy_id), 64'd1);
    check("in_ready_busy", 64'(rdy_ht), 64'd0);
    lat = 1;
    while (!ov_id && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd10);
    check("valid_ht", 64'(ov_ht), 64'd1);
    check("valid_re", 64'(ov_re), 64'd1);
    check("out_id", 64'(ovec_id), 64'(e_id));
    check("out_ht", 64'(ovec_ht), 64'(e_ht));
    check("out_re", 64'(ovec_re), 64'(e_re));
    got_id = ovec_id;
    got_ht = ovec_ht;
    got_re = ovec_re;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(ov_id), 64'd1);
      check("hold_stable", 64'(ovec_id), 64'(e_id));
      check("hold_in_ready", 64'(rdy_id), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_hs_valid", 64'(ov_id), 64'd0);
    check("post_hs_in_ready", 64'(rdy_id), 64'd1);
    check("post_hs_busy", 64'(busy_re), 64'd0);
  endtask

  logic [IN_W-1:0]  x;
  logic [W_W-1:0]   w;
  logic [OUT_W-1:0] r_id, r_ht, r_re;
  logic [15:0]      tmp;

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    in_vec       = '0;
    flat_weights = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(rdy_id), 64'd1);
    check("rst_out_valid", 64'(ov_id), 64'd0);
    check("rst_busy", 64'(busy_id), 64'd0);
    check("rst_out_vec", 64'(ovec_ht), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic / hard tanh / ReLU directed vector, with 5 cycles of backpressure
    x = {16'h0080, 16'h0100};
    w = {16'h0000, 16'h0000, 16'hFE00,
         16'h0000, 16'h0000, 16'hFF00,
         16'h0040, 16'h0100, 16'h0080};
    do_txn(x, w, 5, r_id, r_ht, r_re);
    tmp = r_id[15:0];  check("basic_slot0", 64'(tmp), 64'h0140);
    tmp = r_ht[15:0];  check("htanh_slot0", 64'(tmp), 64'h0100);
    tmp = r_ht[47:32]; check("htanh_neg2", 64'(tmp), 64'hFF00);
    tmp = r_re[31:16]; check("relu_slot1", 64'(tmp), 64'h0000);

    // Overflow: 127.0 * 127.0
    x = {16'h0000, 16'h7F00};
    w = '0;
    w[15:0] = 16'h7F00;
    do_txn(x, w, 0, r_id, r_ht, r_re);
    tmp = r_id[15:0];
`ifdef DENSE_SAT_EN
    check("overflow_sat", 64'(tmp), 64'h7FFF);
`else
    check("overflow_wrap", 64'(tmp), 64'h0100);
`endif

    // Reset in the middle of a computation
    in_vec   = {16'h0100, 16'h0200};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy_id), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", 64'(ov_id), 64'd0);
    check("mid_rst_vec", 64'(ovec_id), 64'd0);
    check("mid_rst_in_ready", 64'(rdy_id), 64'd1);
    check("mid_rst_busy", 64'(busy_id), 64'd0);

    // Randomized vectors: alternate small-magnitude and full-range operands
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < N_IN; k++) begin
        if (t % 2 == 0) x[16*k +: 16] = 16'($urandom_range(0, 1023)) - 16'd512;
        else            x[16*k +: 16] = 16'($urandom);
      end
      for (int s = 0; s < N_OUT * (N_IN + 1); s++) begin
        if (t % 2 == 0) w[16*s +: 16] = 16'($urandom_range(0, 1023)) - 16'd512;
        else            w[16*s +: 16] = 16'($urandom);
      end
      do_txn(x, w, $urandom_range(0, 3), r_id, r_ht, r_re);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
